// File: rtl/iconn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iconn_pkg
// Brief    : Shared widths, flit type and port-count helper for the interconnect.
// Revision : 1.0
// ============================================================================
package iconn_pkg;

    localparam int ICONN_AW_DEF = 5;
    localparam int ICONN_DW_DEF = 64;

    typedef struct packed {
        logic [ICONN_AW_DEF-1:0] addr;
        logic [ICONN_DW_DEF-1:0] data;
    } iconn_flit_t;

    function automatic int port_num(input int aw);
        return 1 << aw;
    endfunction

endpackage : iconn_pkg
`default_nettype wire

// File: rtl/iconn_exchange_switch.sv
`default_nettype none
// ============================================================================
// Module   : iconn_exchange_switch
// Brief    : One registered 2x2 exchange switch with round-robin conflict arbiter.
// Revision : 1.0
// ============================================================================
module iconn_exchange_switch
    import iconn_pkg::*;
#(
    parameter int AW        = ICONN_AW_DEF,
    parameter int DW        = ICONN_DW_DEF,
    parameter int STAGE_BIT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*AW-1:0] i_ain,
    input  logic [2*DW-1:0] i_din,
    input  logic [1:0]      i_din_valid,
    output logic [1:0]      o_din_ready,
    output logic [2*AW-1:0] o_aout,
    output logic [2*DW-1:0] o_dout,
    output logic [1:0]      o_dout_valid,
    input  logic [1:0]      i_dout_ready
);

    logic [1:0] r_valid;
    logic       r_prio;
    logic [1:0] w_tgt;
    logic [1:0] w_free;
    logic [1:0] w_grant;
    logic [1:0] w_load;
    logic [1:0] w_sel;
    logic       w_conflict;

    assign w_tgt[0]   = i_ain[STAGE_BIT];
    assign w_tgt[1]   = i_ain[AW+STAGE_BIT];
    assign w_free     = ~r_valid | i_dout_ready;
    assign w_conflict = (&i_din_valid) && (w_tgt[0] == w_tgt[1]);

    always_comb begin
        w_grant = 2'b00;
        if (w_conflict) begin
            // Only the priority holder may go; the loser waits even if the target is free.
            w_grant[r_prio] = w_free[w_tgt[0]];
        end else begin
            w_grant[0] = i_din_valid[0] & w_free[w_tgt[0]];
            w_grant[1] = i_din_valid[1] & w_free[w_tgt[1]];
        end
    end

    assign w_load[0] = (w_grant[0] & ~w_tgt[0]) | (w_grant[1] & ~w_tgt[1]);
    assign w_sel[0]  = w_grant[1] & ~w_tgt[1];
    assign w_load[1] = (w_grant[0] & w_tgt[0]) | (w_grant[1] & w_tgt[1]);
    assign w_sel[1]  = w_grant[1] & w_tgt[1];

    assign o_din_ready  = w_grant;
    assign o_dout_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_conflict && w_free[w_tgt[0]]) begin
            r_prio <= ~r_prio;
        end
    end

    for (genvar o = 0; o < 2; o++) begin : g_out
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid[o] <= 1'b0;
                r_addr     <= '0;
                r_data     <= '0;
            end else if (w_load[o]) begin
                r_valid[o] <= 1'b1;
                r_addr     <= w_sel[o] ? i_ain[AW +: AW] : i_ain[0 +: AW];
                r_data     <= w_sel[o] ? i_din[DW +: DW] : i_din[0 +: DW];
            end else if (i_dout_ready[o]) begin
                r_valid[o] <= 1'b0;
            end
        end

        assign o_aout[o*AW +: AW] = r_addr;
        assign o_dout[o*DW +: DW] = r_data;
    end

endmodule : iconn_exchange_switch
`default_nettype wire

// File: rtl/iconn_exchange_stage.sv
`default_nettype none
// ============================================================================
// Module   : iconn_exchange_stage
// Brief    : Registered exchange column: PORT_NUM/2 switches steered by one address bit.
// Revision : 1.0
// ============================================================================
module iconn_exchange_stage
    import iconn_pkg::*;
#(
    parameter  int NODE_ADDR_WIDTH = ICONN_AW_DEF,
    parameter  int DATA_WIDTH      = ICONN_DW_DEF,
    parameter  int STAGE_BIT       = 0,
    localparam int PORT_NUM        = port_num(NODE_ADDR_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [PORT_NUM*NODE_ADDR_WIDTH-1:0] ain,
    input  logic [PORT_NUM*DATA_WIDTH-1:0]  din,
    input  logic [PORT_NUM-1:0]             din_valid,
    output logic [PORT_NUM-1:0]             din_ready,
    output logic [PORT_NUM*NODE_ADDR_WIDTH-1:0] aout,
    output logic [PORT_NUM*DATA_WIDTH-1:0]  dout,
    output logic [PORT_NUM-1:0]             dout_valid,
    input  logic [PORT_NUM-1:0]             dout_ready
);

    localparam int AW2 = 2 * NODE_ADDR_WIDTH;
    localparam int DW2 = 2 * DATA_WIDTH;

    for (genvar k = 0; k < PORT_NUM/2; k++) begin : g_switch
        iconn_exchange_switch #(
            .AW        (NODE_ADDR_WIDTH),
            .DW        (DATA_WIDTH),
            .STAGE_BIT (STAGE_BIT)
        ) u_switch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_ain        (ain[k*AW2 +: AW2]),
            .i_din        (din[k*DW2 +: DW2]),
            .i_din_valid  (din_valid[2*k +: 2]),
            .o_din_ready  (din_ready[2*k +: 2]),
            .o_aout       (aout[k*AW2 +: AW2]),
            .o_dout       (dout[k*DW2 +: DW2]),
            .o_dout_valid (dout_valid[2*k +: 2]),
            .i_dout_ready (dout_ready[2*k +: 2])
        );
    end

endmodule : iconn_exchange_stage
`default_nettype wire
